// File: rtl/clock_pkg.sv
// Shared types and BCD limits for the clock blocks (time counter, alarm set, alarm ring).
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  localparam logic [7:0] BCD_MAX_MN_SD = 8'h59;
  localparam logic [7:0] BCD_MAX_HR    = 8'h23;

  // Raw 8-bit equality on all three pairs; malformed BCD only matches itself.
  function automatic logic time_eq(
    input logic [7:0] ha, input logic [7:0] ma, input logic [7:0] sa,
    input logic [7:0] hb, input logic [7:0] mb, input logic [7:0] sb
  );
    return (ha == hb) && (ma == mb) && (sa == sb);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one-cycle pulse on the cycle d is high and was low last cycle.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/alarm_ring.sv
// Alarm compare plus ring/snooze state machine driving a gated square-wave buzzer.
module alarm_ring
  import clock_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int TONE_HALF      = 12500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [7:0] hr_time,
  input  logic [7:0] mn_time,
  input  logic [7:0] sd_time,
  input  logic [7:0] hr_alarm,
  input  logic [7:0] mn_alarm,
  input  logic [7:0] sd_alarm,
  input  logic       alarm_en,
  input  logic       set_mod,
  input  logic       key_stop,
  input  logic       key_snooze,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing
);

  localparam int RW = $clog2(RING_SECONDS + 1);
  localparam int SW = $clog2(SNOOZE_SECONDS + 1);
  localparam int NW = $clog2(MAX_SNOOZE + 1);
  localparam int TW = $clog2(TONE_HALF + 1);

  localparam logic [RW-1:0] RING_LD   = RW'(RING_SECONDS);
  localparam logic [SW-1:0] SNZ_LD    = SW'(SNOOZE_SECONDS);
  localparam logic [NW-1:0] SNZ_MAX   = NW'(MAX_SNOOZE);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

  logic match, match_p, stop_p, snz_p;

  assign match = time_eq(hr_time, mn_time, sd_time, hr_alarm, mn_alarm, sd_alarm);

  edge_rise u_match  (.clk(clk), .rst_n(rst_n), .d(match),      .pulse(match_p));
  edge_rise u_stop   (.clk(clk), .rst_n(rst_n), .d(key_stop),   .pulse(stop_p));
  edge_rise u_snooze (.clk(clk), .rst_n(rst_n), .d(key_snooze), .pulse(snz_p));

  alarm_state_e  state, state_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [NW-1:0] snz_cnt, snz_cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          beep, beep_n, tone, tone_n, enter_ring;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rcnt     <= '0;
      scnt     <= '0;
      snz_cnt  <= '0;
      tcnt     <= '0;
      beep     <= 1'b0;
      tone     <= 1'b0;
      buzzer   <= 1'b0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      state    <= state_n;
      rcnt     <= rcnt_n;
      scnt     <= scnt_n;
      snz_cnt  <= snz_cnt_n;
      tcnt     <= tcnt_n;
      beep     <= beep_n;
      tone     <= tone_n;
      // Outputs follow the next state so they never lag a transition.
      buzzer   <= (state_n == RING) & beep_n & tone_n;
      ringing  <= (state_n == RING);
      snoozing <= (state_n == SNOOZE);
    end
  end

  always_comb begin
    state_n    = state;
    rcnt_n     = rcnt;
    scnt_n     = scnt;
    snz_cnt_n  = snz_cnt;
    tcnt_n     = tcnt;
    beep_n     = beep;
    tone_n     = tone;
    enter_ring = 1'b0;

    if (set_mod || !alarm_en) begin
      state_n   = IDLE;
      snz_cnt_n = '0;
    end else if (stop_p) begin
      state_n = IDLE;
    end else if (snz_p && state == RING) begin
      if (snz_cnt < SNZ_MAX) begin
        state_n   = SNOOZE;
        scnt_n    = SNZ_LD;
        snz_cnt_n = snz_cnt + 1'b1;
      end else begin
        state_n = IDLE;
      end
    end else if (sec_tick && state == RING) begin
      beep_n = ~beep;
      if (rcnt == RW'(1)) state_n = IDLE;
      else                rcnt_n  = rcnt - 1'b1;
    end else if (sec_tick && state == SNOOZE) begin
      if (scnt == SW'(1)) enter_ring = 1'b1;
      else                scnt_n     = scnt - 1'b1;
    end else if (match_p && state == IDLE) begin
      enter_ring = 1'b1;
      snz_cnt_n  = '0;
    end

    // Tone starts high on entry so the first beep sounds immediately.
    if (enter_ring) begin
      state_n = RING;
      rcnt_n  = RING_LD;
      beep_n  = 1'b1;
      tcnt_n  = '0;
      tone_n  = 1'b1;
    end else if (state == RING && state_n == RING) begin
      if (tcnt == TONE_LAST) begin
        tcnt_n = '0;
        tone_n = ~tone;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alarm_ring.sv
// Directed test-plan scenarios then random stimulus against a seconds/cycles reference model.
module tb_alarm_ring;

  localparam int RS = 5, SS = 3, MS = 2, TH = 2;

  logic       clk = 1'b0;
  logic       rst_n, sec_tick, alarm_en, set_mod, key_stop, key_snooze;
  logic [7:0] hr_time, mn_time, sd_time, hr_alarm, mn_alarm, sd_alarm;
  logic       buzzer, ringing, snoozing;

  int n_chk = 0, n_fail = 0;

  // Model: mode 0 idle, 1 ring, 2 snooze; ring progress kept as elapsed seconds/cycles.
  int m_st, m_ticks, m_cyc, m_left, m_scount;
  bit pm, ps, pz;

  always #5 clk = ~clk;

  alarm_ring #(.RING_SECONDS(RS), .SNOOZE_SECONDS(SS), .MAX_SNOOZE(MS), .TONE_HALF(TH)) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick),
    .hr_time(hr_time), .mn_time(mn_time), .sd_time(sd_time),
    .hr_alarm(hr_alarm), .mn_alarm(mn_alarm), .sd_alarm(sd_alarm),
    .alarm_en(alarm_en), .set_mod(set_mod), .key_stop(key_stop), .key_snooze(key_snooze),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ticks = 0; m_cyc = 0; m_left = 0; m_scount = 0;
    pm = 0; ps = 0; pz = 0;
  endtask

  task automatic start_ring();
    m_st = 1; m_ticks = 0; m_cyc = 0;
  endtask

  // Applies the current input values as the next clock edge will see them.
  task automatic model_step();
    bit mt, me, se, ze, entered;
    int prev;
    if (!rst_n) begin model_reset(); return; end
    mt = (hr_time == hr_alarm) && (mn_time == mn_alarm) && (sd_time == sd_alarm);
    me = mt && !pm; se = key_stop && !ps; ze = key_snooze && !pz;
    pm = mt; ps = key_stop; pz = key_snooze;
    prev = m_st; entered = 0;
    if (set_mod || !alarm_en) begin m_st = 0; m_scount = 0; end
    else if (se) m_st = 0;
    else if (ze && m_st == 1) begin
      if (m_scount < MS) begin m_st = 2; m_left = SS; m_scount++; end
      else m_st = 0;
    end
    else if (sec_tick && m_st == 1) begin
      m_ticks++;
      if (m_ticks == RS) m_st = 0;
    end
    else if (sec_tick && m_st == 2) begin
      m_left--;
      if (m_left == 0) begin start_ring(); entered = 1; end
    end
    else if (me && m_st == 0) begin start_ring(); entered = 1; m_scount = 0; end
    if (!entered && prev == 1 && m_st == 1) m_cyc++;
  endtask

  task automatic check_all();
    bit eb;
    eb = (m_st == 1) && (m_ticks % 2 == 0) && ((m_cyc / TH) % 2 == 0);
    chk("ringing",  ringing,  m_st == 1);
    chk("snoozing", snoozing, m_st == 2);
    chk("buzzer",   buzzer,   eb);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    sec_tick = 1; cyc(); sec_tick = 0;
  endtask

  task automatic press_snz();
    key_snooze = 1; cyc(); key_snooze = 0; cyc();
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hr_time = h; mn_time = m; sd_time = s;
  endtask

  task automatic trigger();
    set_time(8'h07, 8'h29, 8'h59); cyc();
    set_time(8'h07, 8'h30, 8'h00); cyc();
  endtask

  initial begin
    int unsigned r;
    rst_n = 0; sec_tick = 0; alarm_en = 1; set_mod = 0; key_stop = 0; key_snooze = 0;
    hr_alarm = 8'h07; mn_alarm = 8'h30; sd_alarm = 8'h00;
    set_time(8'h07, 8'h29, 8'h59);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ringing", ringing, 0);
    chk("rst_snoozing", snoozing, 0);
    chk("rst_buzzer", buzzer, 0);
    rst_n = 1;

    // Ring, tone pattern, auto-stop after RS seconds.
    trigger();
    chk("ring_latency", ringing, 1);
    repeat (6) cyc();
    for (int i = 0; i < RS; i++) begin tick(); repeat (2) cyc(); end
    chk("ring_auto_off", ringing, 0);
    chk("ring_auto_buz", buzzer, 0);

    // Two snoozes allowed, third press stops.
    trigger();
    press_snz();
    chk("snz1_on", snoozing, 1);
    chk("snz1_buz", buzzer, 0);
    repeat (SS) begin tick(); cyc(); end
    chk("snz1_back", ringing, 1);
    press_snz();
    chk("snz2_on", snoozing, 1);
    repeat (SS) begin tick(); cyc(); end
    chk("snz2_back", ringing, 1);
    press_snz();
    chk("snz3_ring", ringing, 0);
    chk("snz3_snz", snoozing, 0);

    // Stop wins over a simultaneous snooze.
    trigger();
    key_stop = 1; key_snooze = 1; cyc();
    chk("stop_snz_ring", ringing, 0);
    chk("stop_snz_snz", snoozing, 0);
    key_stop = 0; key_snooze = 0; cyc();

    // set_mod aborts; standing match must not retrigger on release.
    trigger(); cyc();
    set_mod = 1; cyc();
    chk("setmod_idle", ringing, 0);
    set_mod = 0; repeat (4) cyc();
    chk("no_retrigger", ringing, 0);

    // Asynchronous reset in SNOOZE, then disabled alarm at match time.
    trigger();
    press_snz();
    chk("pre_rst_snz", snoozing, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_snz", snoozing, 0);
    chk("rst_async_buz", buzzer, 0);
    model_reset();
    alarm_en = 0;
    set_time(8'h07, 8'h29, 8'h59);
    cyc();
    rst_n = 1;
    trigger();
    repeat (3) cyc();
    chk("en_off_ring", ringing, 0);
    alarm_en = 1; repeat (2) cyc();
    chk("en_on_standing", ringing, 0);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      sec_tick = ($urandom % 4) == 0;
      r = $urandom % 8;
      if (r == 4 || r == 5) set_time(hr_alarm, mn_alarm, sd_alarm);
      else if (r == 6) set_time(hr_alarm, mn_alarm, sd_alarm ^ 8'h01);
      else if (r == 7 && ($urandom % 4) == 0) set_time(8'($urandom), 8'($urandom), 8'($urandom));
      if (($urandom % 20) == 0)  key_stop   = ~key_stop;
      if (($urandom % 12) == 0)  key_snooze = ~key_snooze;
      if (($urandom % 100) == 0) set_mod    = ~set_mod;
      if (($urandom % 150) == 0) alarm_en   = ~alarm_en;
      if (set_mod && ($urandom % 8) == 0) set_mod = 0;
      if (!alarm_en && ($urandom % 10) == 0) alarm_en = 1;
      if (($urandom % 300) == 0) begin
        hr_alarm = 8'($urandom_range(0, 35)); mn_alarm = 8'($urandom_range(0, 89));
        sd_alarm = 8'($urandom_range(0, 89));
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
